// File: rtl/bt_car_pkg.sv
// Shared constants for the Bluetooth car controller: command bytes,
// H-bridge direction encodings, RX FSM states and small helpers.
package bt_car_pkg;

  localparam logic [7:0] CMD_A = 8'h41;
  localparam logic [7:0] CMD_B = 8'h42;
  localparam logic [7:0] CMD_C = 8'h43;
  localparam logic [7:0] CMD_D = 8'h44;
  localparam logic [7:0] CMD_E = 8'h45;
  localparam logic [7:0] CMD_F = 8'h46;
  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] CMD_H = 8'h48;
  localparam logic [7:0] CMD_I = 8'h49;
  localparam logic [7:0] CMD_0 = 8'h30;
  localparam logic [7:0] CMD_9 = 8'h39;

  // {IOb, IOa} per channel
  localparam logic [1:0] DIR_OFF = 2'b00;
  localparam logic [1:0] DIR_FWD = 2'b01;
  localparam logic [1:0] DIR_REV = 2'b10;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  // Requested motion of one channel; fast selects the base duty.
  typedef struct packed {
    logic [1:0] dir;
    logic       fast;
  } ch_cmd_t;

  function automatic ch_cmd_t mk_cmd(input logic [1:0] dir, input logic fast);
    ch_cmd_t c;
    c.dir  = dir;
    c.fast = fast;
    return c;
  endfunction

  // Rounded clk-per-oversample-tick divider, never below 1.
  function automatic int baud_div(input int clk_hz, input int baud, input int osr);
    int d;
    d = (clk_hz + (baud * osr) / 2) / (baud * osr);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-FF synchroniser, baud tick divider and
// start/data/stop FSM. Optional even parity with `define RX_PARITY_EN.
module uart_rx_os
  import bt_car_pkg::*;
#(
  parameter int CLK_HZ = 25000000,
  parameter int BAUD   = 9600,
  parameter int OSR    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int DIV = baud_div(CLK_HZ, BAUD, OSR);
  localparam int DW  = $clog2(DIV + 1);
  localparam int TW  = $clog2(OSR + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [TW-1:0] T_MID    = TW'(OSR / 2 - 1);
  localparam logic [TW-1:0] T_FULL   = TW'(OSR - 1);

  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DW-1:0] div_q, div_d;
  logic          tick;
  rx_state_e     state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          par_bad;
`ifdef RX_PARITY_EN
  logic          par_q, par_d;
`endif

  // synchroniser input and free-running oversample tick divider
  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    tick    = (div_q == DIV_LAST);
    div_d   = tick ? '0 : div_q + 1'b1;
  end

  // all receiver state; synchroniser idles high so reset looks like line idle
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      div_q   <= '0;
      state_q <= RX_IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      div_q   <= div_d;
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

`ifdef RX_PARITY_EN
  // captured parity bit of the frame in flight
  always_ff @(posedge clk) begin
    if (!reset) par_q <= 1'b0;
    else        par_q <= par_d;
  end
  assign par_bad = (par_q != ^shreg_q);
`else
  assign par_bad = 1'b0;
`endif

  // frame FSM: tick counter restarts at each phase so samples land mid-bit
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef RX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      RX_IDLE: begin
        if (!sync2_q) begin
          state_d = RX_START;
          tcnt_d  = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          if (tcnt_q == T_MID) begin
            tcnt_d  = '0;
            bcnt_d  = '0;
            state_d = sync2_q ? RX_IDLE : RX_DATA;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (tcnt_q == T_FULL) begin
            tcnt_d  = '0;
            shreg_d = {sync2_q, shreg_q[7:1]};
            if (bcnt_q == 3'd7) begin
`ifdef RX_PARITY_EN
              state_d = RX_PARITY;
`else
              state_d = RX_STOP;
`endif
            end else begin
              bcnt_d = bcnt_q + 3'd1;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      RX_PARITY: begin
`ifdef RX_PARITY_EN
        if (tick) begin
          if (tcnt_q == T_FULL) begin
            tcnt_d  = '0;
            par_d   = sync2_q;
            state_d = RX_STOP;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
`else
        state_d = RX_IDLE;
`endif
      end
      RX_STOP: begin
        if (tick) begin
          if (tcnt_q == T_FULL) begin
            tcnt_d = '0;
            if (!sync2_q) begin
              ferr_d  = 1'b1;
              state_d = RX_BREAK;
            end else if (par_bad) begin
              ferr_d  = 1'b1;
              state_d = RX_IDLE;
            end else begin
              valid_d = 1'b1;
              data_d  = shreg_q;
              state_d = RX_IDLE;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      RX_BREAK: begin
        if (sync2_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign data       = data_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/bt_motor_ctrl_p.sv
// Bluetooth car controller top: UART command decode, speed cap, per-channel
// duty ramp with reversal interlock, link watchdog and PWM generation.
// Build option: RX_PARITY_EN (even parity in the UART frame).
module bt_motor_ctrl_p
  import bt_car_pkg::*;
#(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 9600,
  parameter int OSR        = 16,
  parameter int PWM_BITS   = 8,
  parameter int PWM_DIV    = 2048,
  parameter int DUTY_FAST  = 155,
  parameter int DUTY_SLOW  = 90,
  parameter int SPEED_STEP = 28,
  parameter int RAMP_DIV   = 4096,
  parameter int RAMP_STEP  = 1,
  parameter int WDOG_CYC   = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] leds,
  output logic [3:0] io,
  output logic [1:0] pwm,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       wdog_trip
);

  localparam int NCH  = 2;
  localparam int DMAX = (1 << PWM_BITS) - 1;
  localparam int RW   = $clog2(RAMP_DIV + 1);
  localparam int PW   = $clog2(PWM_DIV + 1);
  localparam int WW   = $clog2(WDOG_CYC + 1);
  localparam logic [PWM_BITS-1:0] DMAX_L = PWM_BITS'(DMAX);
  localparam logic [PWM_BITS-1:0] FAST_D = PWM_BITS'((DUTY_FAST > DMAX) ? DMAX : DUTY_FAST);
  localparam logic [PWM_BITS-1:0] SLOW_D = PWM_BITS'((DUTY_SLOW > DMAX) ? DMAX : DUTY_SLOW);
  localparam logic [PWM_BITS-1:0] STEP_L = PWM_BITS'((RAMP_STEP > DMAX) ? DMAX : RAMP_STEP);
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);
  localparam logic [PW-1:0] PDIV_LAST = PW'(PWM_DIV - 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYC - 1);

  logic [7:0] rx_data;
  logic       rx_valid, rx_err;

  uart_rx_os #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .OSR    (OSR)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data       (rx_data),
    .byte_valid (rx_valid),
    .frame_err  (rx_err)
  );

  logic [7:0]              leds_q, leds_d;
  logic [PWM_BITS-1:0]     cap_q, cap_d;
  ch_cmd_t [NCH-1:0]       cmd_q, cmd_d;
  logic                    trip_q, trip_d;
  logic [WW-1:0]           wdog_q, wdog_d;
  logic [RW-1:0]           ramp_q, ramp_d;
  logic [PW-1:0]           pdiv_q, pdiv_d;
  logic [PWM_BITS-1:0]     pcnt_q, pcnt_d;
  logic                    ramp_tick;
  int                      cap_w;

  // command decode, speed cap and watchdog; a received byte beats a trip
  always_comb begin
    leds_d = leds_q;
    cap_d  = cap_q;
    cmd_d  = cmd_q;
    trip_d = trip_q;
    wdog_d = (wdog_q == WDOG_LAST) ? wdog_q : wdog_q + 1'b1;
    cap_w  = int'(rx_data[3:0]) * SPEED_STEP;
    if (rx_valid) begin
      leds_d = rx_data;
      wdog_d = '0;
      if (rx_data >= CMD_0 && rx_data <= CMD_9)
        cap_d = (cap_w > DMAX) ? DMAX_L : PWM_BITS'(cap_w);
      if (rx_data >= CMD_A && rx_data <= CMD_I)
        trip_d = 1'b0;
      case (rx_data)
        CMD_A: begin cmd_d[0] = mk_cmd(DIR_FWD, 1'b1); cmd_d[1] = mk_cmd(DIR_FWD, 1'b1); end
        CMD_B: begin cmd_d[0] = mk_cmd(DIR_REV, 1'b1); cmd_d[1] = mk_cmd(DIR_REV, 1'b1); end
        CMD_C: begin cmd_d[0] = mk_cmd(DIR_OFF, 1'b0); cmd_d[1] = mk_cmd(DIR_OFF, 1'b0); end
        CMD_D: begin cmd_d[0] = mk_cmd(DIR_OFF, 1'b0); cmd_d[1] = mk_cmd(DIR_FWD, 1'b1); end
        CMD_E: begin cmd_d[0] = mk_cmd(DIR_FWD, 1'b1); cmd_d[1] = mk_cmd(DIR_OFF, 1'b0); end
        CMD_F: begin cmd_d[0] = mk_cmd(DIR_FWD, 1'b0); cmd_d[1] = mk_cmd(DIR_FWD, 1'b1); end
        CMD_G: begin cmd_d[0] = mk_cmd(DIR_FWD, 1'b1); cmd_d[1] = mk_cmd(DIR_FWD, 1'b0); end
        CMD_H: begin cmd_d[0] = mk_cmd(DIR_REV, 1'b1); cmd_d[1] = mk_cmd(DIR_REV, 1'b0); end
        CMD_I: begin cmd_d[0] = mk_cmd(DIR_REV, 1'b0); cmd_d[1] = mk_cmd(DIR_REV, 1'b1); end
        default: ;
      endcase
    end else if (wdog_q == WDOG_LAST) begin
      cmd_d[0] = mk_cmd(DIR_OFF, 1'b0);
      cmd_d[1] = mk_cmd(DIR_OFF, 1'b0);
      trip_d   = 1'b1;
    end
  end

  // shared ramp and PWM timebases
  always_comb begin
    ramp_tick = (ramp_q == RAMP_LAST);
    ramp_d    = ramp_tick ? '0 : ramp_q + 1'b1;
    pdiv_d    = (pdiv_q == PDIV_LAST) ? '0 : pdiv_q + 1'b1;
    pcnt_d    = (pdiv_q == PDIV_LAST) ? pcnt_q + 1'b1 : pcnt_q;
  end

  // decoder, watchdog and timebase registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      leds_q <= '0;
      cap_q  <= DMAX_L;
      cmd_q  <= '0;
      trip_q <= 1'b0;
      wdog_q <= '0;
      ramp_q <= '0;
      pdiv_q <= '0;
      pcnt_q <= '0;
    end else begin
      leds_q <= leds_d;
      cap_q  <= cap_d;
      cmd_q  <= cmd_d;
      trip_q <= trip_d;
      wdog_q <= wdog_d;
      ramp_q <= ramp_d;
      pdiv_q <= pdiv_d;
      pcnt_q <= pcnt_d;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [PWM_BITS-1:0] base, tgt, eff, duty_q, duty_d;
    logic [1:0]          app_q, app_d;
    logic                pwm_q, pwm_d;

    // target = min(base, cap); a pending direction change drives the duty to
    // zero first, and the new dir is latched once zero has been observed
    always_comb begin
      base = cmd_q[c].fast ? FAST_D : SLOW_D;
      if (cmd_q[c].dir == DIR_OFF) base = '0;
      tgt   = (base < cap_q) ? base : cap_q;
      eff   = tgt;
      app_d = app_q;
      if (cmd_q[c].dir != app_q) begin
        eff = '0;
        if (duty_q == '0) app_d = cmd_q[c].dir;
      end
      duty_d = duty_q;
      if (ramp_tick) begin
        if (duty_q < eff)
          duty_d = (eff - duty_q > STEP_L) ? duty_q + STEP_L : eff;
        else if (duty_q > eff)
          duty_d = (duty_q - eff > STEP_L) ? duty_q - STEP_L : eff;
      end
      pwm_d = (pcnt_q < duty_q);
    end

    // per-channel duty, applied direction and registered PWM output
    always_ff @(posedge clk) begin
      if (!reset) begin
        duty_q <= '0;
        app_q  <= DIR_OFF;
        pwm_q  <= 1'b0;
      end else begin
        duty_q <= duty_d;
        app_q  <= app_d;
        pwm_q  <= pwm_d;
      end
    end

    assign io[2*c +: 2] = app_q;
    assign pwm[c]       = pwm_q;
  end

  assign leds       = leds_q;
  assign byte_valid = rx_valid;
  assign frame_err  = rx_err;
  assign wdog_trip  = trip_q;

endmodule

// File: tb/tb_bt_motor_ctrl_p.sv
// Scoreboard bench for bt_motor_ctrl_p with scaled-down timing parameters.
module tb_bt_motor_ctrl_p;

  localparam int CLK_HZ   = 307200;   // divider = 2 clk per oversample tick
  localparam int BAUD     = 9600;
  localparam int OSR      = 16;
  localparam int PWM_DIV  = 1;
  localparam int RAMP_DIV = 4;
  localparam int WDOG_CYC = 6000;
  localparam int DF       = 155;
  localparam int DS       = 90;
  localparam int SSTEP    = 28;
  localparam int BITC     = OSR * 2;
  localparam int SETTLE   = 1400;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] leds;
  logic [3:0] io;
  logic [1:0] pwm;
  logic       byte_valid, frame_err, wdog_trip;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [1:0] kind;   // {byte_valid, frame_err}
    logic [7:0] leds;
  } ev_t;
  ev_t exp_q[$];

  // reference model state
  int         m_cap;
  int         m_dir [2];
  int         m_base[2];
  logic       m_trip;
  logic [7:0] m_leds;

  always #5 clk = ~clk;

  bt_motor_ctrl_p #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OSR(OSR), .PWM_BITS(8), .PWM_DIV(PWM_DIV),
    .DUTY_FAST(DF), .DUTY_SLOW(DS), .SPEED_STEP(SSTEP), .RAMP_DIV(RAMP_DIV),
    .RAMP_STEP(1), .WDOG_CYC(WDOG_CYC)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .leds(leds), .io(io), .pwm(pwm),
    .byte_valid(byte_valid), .frame_err(frame_err), .wdog_trip(wdog_trip)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_duty(input int c);
    if (m_dir[c] == 0) return 0;
    return (m_base[c] < m_cap) ? m_base[c] : m_cap;
  endfunction

  function automatic logic [3:0] exp_io();
    return 4'(m_dir[1] * 4 + m_dir[0]);
  endfunction

  task automatic model_reset();
    m_cap = 255; m_dir = '{0, 0}; m_base = '{0, 0}; m_trip = 1'b0; m_leds = 8'h00;
  endtask

  task automatic set2(input int d0, input int b0, input int d1, input int b1);
    m_dir[0] = d0; m_base[0] = b0; m_dir[1] = d1; m_base[1] = b1;
  endtask

  // dir: 0 off, 1 forward, 2 reverse; channel 0 is the right motor
  task automatic model_cmd(input logic [7:0] b);
    case (b)
      8'h41: set2(1, DF, 1, DF);
      8'h42: set2(2, DF, 2, DF);
      8'h43: set2(0, 0, 0, 0);
      8'h44: set2(0, 0, 1, DF);
      8'h45: set2(1, DF, 0, 0);
      8'h46: set2(1, DS, 1, DF);
      8'h47: set2(1, DF, 1, DS);
      8'h48: set2(2, DF, 2, DS);
      8'h49: set2(2, DS, 2, DF);
      default: if (b >= 8'h30 && b <= 8'h39) begin
        m_cap = (int'(b) - 48) * SSTEP;
        if (m_cap > 255) m_cap = 255;
      end
    endcase
    if (b >= 8'h41 && b <= 8'h49) m_trip = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0; repeat (BITC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin rx = b[i]; repeat (BITC) @(negedge clk); end
`ifdef RX_PARITY_EN
    rx = ^b; repeat (BITC) @(negedge clk);
`endif
    rx = stop_bit; repeat (BITC) @(negedge clk);
    rx = 1'b1; repeat (BITC) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] b);
    exp_q.push_back({2'b10, b});
    m_leds = b;
    model_cmd(b);
    send_frame(b, 1'b1);
  endtask

  task automatic send_bad(input logic [7:0] b);
    exp_q.push_back({2'b01, m_leds});
    send_frame(b, 1'b0);
  endtask

  // wait for the ramp to finish, then measure one full PWM period per channel
  task automatic check_motor(input string tag);
    int h0, h1;
    h0 = 0; h1 = 0;
    repeat (SETTLE) @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      h0 += int'(pwm[0]);
      h1 += int'(pwm[1]);
    end
    chk($sformatf("%s io", tag), 32'(io), 32'(exp_io()));
    chk($sformatf("%s duty0", tag), 32'(h0), 32'(exp_duty(0)));
    chk($sformatf("%s duty1", tag), 32'(h1), 32'(exp_duty(1)));
    chk($sformatf("%s wdog_trip", tag), 32'(wdog_trip), 32'(m_trip));
  endtask

  // monitor: every byte_valid/frame_err pulse must match the next queued event
  initial begin
    ev_t        e;
    logic       pend;
    logic [7:0] pl;
    pend = 1'b0;
    pl   = 8'h00;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("leds after event", 32'(leds), 32'(pl));
        pend = 1'b0;
      end
      if (reset && (byte_valid || frame_err)) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected event: got valid=%0b ferr=%0b, none queued", byte_valid, frame_err);
        end else begin
          e = exp_q.pop_front();
          chk("event kind", 32'({byte_valid, frame_err}), 32'(e.kind));
          pl   = e.leds;
          pend = 1'b1;
        end
      end
    end
  end

  // bounded run time
  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL timeout: simulation did not complete, got %0d tests, required completion", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    reset = 1'b0;
    rx    = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset leds", 32'(leds), 0);
    chk("reset io", 32'(io), 0);
    chk("reset pwm", 32'(pwm), 0);
    chk("reset byte_valid", 32'(byte_valid), 0);
    chk("reset frame_err", 32'(frame_err), 0);
    chk("reset wdog_trip", 32'(wdog_trip), 0);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    // forward, then reversal through zero
    send_good(8'h41); check_motor("A");
    send_good(8'h42);
    repeat (100) @(negedge clk);
    chk("interlock holds io", 32'(io), 32'(4'b0101));
    check_motor("B");

    // speed cap
    send_good(8'h33); check_motor("cap3");
    send_good(8'h41); check_motor("cap3 A");
    send_good(8'h39); check_motor("cap9");
    send_good(8'h46); check_motor("F");
    send_good(8'h49); check_motor("I");

    // short start glitch is rejected silently
    rx = 1'b0; repeat (10) @(negedge clk);
    rx = 1'b1; repeat (300) @(negedge clk);
    chk("glitch leds", 32'(leds), 32'(m_leds));

    // bad stop bit, then a good stop command
    send_bad(8'h43);
    repeat (50) @(negedge clk);
    chk("ferr leds", 32'(leds), 32'(m_leds));
    send_good(8'h43); check_motor("C");

    // watchdog
    send_good(8'h41); check_motor("wd A");
    repeat (WDOG_CYC) @(negedge clk);
    m_trip = 1'b1; set2(0, 0, 0, 0);
    check_motor("wd trip");
    send_good(8'h41);
    chk("wdog cleared", 32'(wdog_trip), 0);
    check_motor("wd resume");

    // reset in the middle of a data bit of 'A'
    rx = 1'b0; repeat (BITC) @(negedge clk);
    for (int i = 0; i < 3; i++) begin rx = 8'h41 >> i; repeat (BITC) @(negedge clk); end
    rx = 1'b0; repeat (BITC / 2) @(negedge clk);
    reset = 1'b0; rx = 1'b1;
    @(negedge clk);
    chk("midreset leds", 32'(leds), 0);
    chk("midreset io", 32'(io), 0);
    chk("midreset pwm", 32'(pwm), 0);
    chk("midreset wdog_trip", 32'(wdog_trip), 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (400) @(negedge clk);
    send_good(8'h42); check_motor("post reset B");

    // randomized command stream
    for (int it = 0; it < 12; it++) begin
      int         r;
      logic [7:0] b;
      r = $urandom_range(0, 20);
      if (r <= 8)       b = 8'(8'h41 + r);
      else if (r <= 18) b = 8'(8'h30 + r - 9);
      else              b = 8'(8'h61 + $urandom_range(0, 25));
      if (r == 20) send_bad(8'($urandom));
      else         send_good(b);
      check_motor($sformatf("rand%0d 0x%02h", it, b));
    end

    repeat (20) @(negedge clk);
    chk("queue empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
